// File: rtl/axi_bridge_mc.sv
// axi_bridge_mc
// Cache-to-AXI bridge. N_RD read clients share one AR slot through round-robin
// arbitration and get their R beats back by ID (client i uses ID i). A single
// write client owns AW/W/B through a one-line write buffer with a beat counter.
// A read whose line matches the buffered (or just-accepted) write line is held
// back until the write has completed.
// Ports:
//   aclk, reset            clock, synchronous active-high reset
//   rd_req/rd_type/rd_addr read requests, one slot per client
//   rd_rdy                 one-cycle grant per client
//   ret_valid/last/data    read return, routed by rid
//   wr_req/type/addr/wstrb/data, wr_rdy, wr_done   write client interface
//   ar*, r*, aw*, w*, b*   AXI master channels (lock/cache/prot tied to 0)
module axi_bridge_mc #(
  parameter int N_RD       = 2,
  parameter int LINE_WORDS = 4,
  parameter int ID_W       = 4,
  parameter int WR_ID      = 1
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic [N_RD-1:0]         rd_req,
  input  logic [N_RD-1:0]         rd_type,
  input  logic [32*N_RD-1:0]      rd_addr,
  output logic [N_RD-1:0]         rd_rdy,
  output logic [N_RD-1:0]         ret_valid,
  output logic                    ret_last,
  output logic [31:0]             ret_data,
  input  logic                    wr_req,
  input  logic                    wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    wr_done,
  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ID_W-1:0]         awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_W-1:0]         wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_W-1:0]         bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int OFF = $clog2(4 * LINE_WORDS);     // byte offset bits within a line
  localparam int CW  = $clog2(LINE_WORDS);          // beat counter width
  localparam int PW  = (N_RD > 1) ? $clog2(N_RD) : 1;

  typedef enum logic [1:0] {W_IDLE, W_AW, W_DAT, W_RSP} wstate_t;

  wstate_t                 r_wstate;
  logic [CW-1:0]           r_wcnt;
  logic [31:0]             r_waddr;
  logic                    r_wtype;
  logic [3:0]              r_wstrb;
  logic [32*LINE_WORDS-1:0] r_wdata;

  logic                    r_arvalid;
  logic [ID_W-1:0]         r_arid;
  logic [31:0]             r_araddr;
  logic [7:0]              r_arlen;
  logic [PW-1:0]           r_ptr;
  logic [N_RD-1:0]         r_pend;   // 1 = client has a read outstanding

  logic                    w_wr_acc;
  logic                    w_slot_ok;
  logic [N_RD-1:0]         w_elig;
  logic [N_RD-1:0]         w_grant;
  logic                    w_gfound;
  logic [PW-1:0]           w_gidx;
  logic [7:0]              w_awlen;
  logic                    w_wlast;

  assign wr_rdy    = (r_wstate == W_IDLE);
  assign w_wr_acc  = wr_req & wr_rdy & ~reset;
  assign w_slot_ok = (~r_arvalid | arready) & ~reset;

  // Hazard and eligibility: a read is blocked while its line matches the
  // buffered write line, or the line of a write being accepted this cycle.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_RD; i++) begin
      w_elig[i] = rd_req[i] & ~r_pend[i]
        & ~((r_wstate != W_IDLE) && (rd_addr[32*i+OFF +: 32-OFF] == r_waddr[31:OFF]))
        & ~(w_wr_acc && (rd_addr[32*i+OFF +: 32-OFF] == wr_addr[31:OFF]));
    end
  end

  // Round-robin pick: first eligible client at or after r_ptr.
  // NOTE: combinational blocks use blocking '=' with defaults assigned first so
  // no latch is inferred; clocked blocks below use non-blocking '<='.
  always_comb begin
    int c;
    c        = 0;
    w_grant  = '0;
    w_gfound = 1'b0;
    w_gidx   = '0;
    for (int o = 0; o < N_RD; o++) begin
      c = (int'(r_ptr) + o) % N_RD;
      if (!w_gfound && w_slot_ok && w_elig[c]) begin
        w_gfound   = 1'b1;
        w_gidx     = PW'(c);
        w_grant[c] = 1'b1;
      end
    end
  end

  assign rd_rdy = w_grant;

  // Zero-latency return routing by ID.
  always_comb begin
    ret_valid = '0;
    for (int i = 0; i < N_RD; i++) ret_valid[i] = rvalid & (rid == ID_W'(i)) & ~reset;
  end
  assign ret_data = rdata;
  assign ret_last = rlast;

  assign w_awlen = r_wtype ? 8'(LINE_WORDS - 1) : 8'd0;
  assign w_wlast = ({{(8-CW){1'b0}}, r_wcnt} == w_awlen);

  // Control state: AR slot, RR pointer, per-client pending bits, write FSM.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_arvalid <= 1'b0;
      r_ptr     <= '0;
      r_pend    <= '0;
      r_wstate  <= W_IDLE;
      r_wcnt    <= '0;
    end else begin
      if (r_arvalid && arready) r_arvalid <= 1'b0;
      if (w_gfound) begin
        r_arvalid <= 1'b1;
        r_ptr     <= (int'(w_gidx) == N_RD - 1) ? '0 : w_gidx + 1'b1;
      end
      for (int i = 0; i < N_RD; i++) begin
        if (rvalid && rlast && rid == ID_W'(i)) r_pend[i] <= 1'b0;
        if (w_grant[i]) r_pend[i] <= 1'b1;
      end
      case (r_wstate)
        W_IDLE: if (w_wr_acc) r_wstate <= W_AW;
        W_AW: if (awready) begin
          r_wstate <= W_DAT;
          r_wcnt   <= '0;
        end
        W_DAT: if (wready) begin
          if (w_wlast) r_wstate <= W_RSP;
          else         r_wcnt   <= r_wcnt + 1'b1;
        end
        W_RSP: if (bvalid) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while the
  // matching valid/state bit (which is reset) says they hold a live request.
  always_ff @(posedge aclk) begin
    if (w_gfound) begin
      r_arid   <= ID_W'(w_gidx);
      r_araddr <= rd_addr[32*w_gidx +: 32];
      r_arlen  <= rd_type[w_gidx] ? 8'(LINE_WORDS - 1) : 8'd0;
    end
    if (w_wr_acc) begin
      r_waddr <= wr_addr;
      r_wtype <= wr_type;
      r_wstrb <= wr_wstrb;
      r_wdata <= wr_data;
    end
  end

  assign arvalid = r_arvalid;
  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign rready  = ~reset;

  assign awvalid = (r_wstate == W_AW);
  assign awid    = ID_W'(WR_ID);
  assign awaddr  = r_waddr;
  assign awlen   = w_awlen;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wvalid  = (r_wstate == W_DAT);
  assign wid     = ID_W'(WR_ID);
  assign wdata   = r_wdata[{r_wcnt, 5'b0} +: 32];
  assign wstrb   = r_wtype ? 4'hf : r_wstrb;
  assign wlast   = w_wlast;

  assign bready  = ~reset;
  assign wr_done = (r_wstate == W_RSP) & bvalid;

  // Response codes and bid are not interpreted by this bridge.
  logic w_unused;
  assign w_unused = ^{rresp, bid, bresp};

endmodule

// File: tb/tb_axi_bridge_mc.sv
// Directed testbench for axi_bridge_mc (N_RD=2, LINE_WORDS=4, ID_W=4, WR_ID=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units
// later, well away from the next edge.
module tb_axi_bridge_mc;
  localparam int N_RD = 2, LW = 4, ID_W = 4, WR_ID = 1;

  logic aclk, reset;
  logic [N_RD-1:0] rd_req, rd_type, rd_rdy, ret_valid;
  logic [32*N_RD-1:0] rd_addr;
  logic ret_last;
  logic [31:0] ret_data;
  logic wr_req, wr_type, wr_rdy, wr_done;
  logic [31:0] wr_addr;
  logic [3:0] wr_wstrb;
  logic [32*LW-1:0] wr_data;
  logic [ID_W-1:0] arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0] arcache, awcache, wstrb;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_w [LW];

  axi_bridge_mc #(.N_RD(N_RD), .LINE_WORDS(LW), .ID_W(ID_W), .WR_ID(WR_ID)) dut (
    .aclk(aclk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic start_line_write(input logic [31:0] addr);
    wr_req  = 1'b1;
    wr_type = 1'b1;
    wr_addr = addr;
    wr_data = {exp_w[3], exp_w[2], exp_w[1], exp_w[0]};
  endtask

  initial begin
    int beat, cyc;
    exp_w[0] = 32'hA0000000; exp_w[1] = 32'hA0000001;
    exp_w[2] = 32'hA0000002; exp_w[3] = 32'hA0000003;
    reset = 1'b1;
    rd_req = '0; rd_type = '0; rd_addr = '0;
    wr_req = 1'b0; wr_type = 1'b0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    step(); step();
    reset = 1'b0;
    settle();

    // Reset state
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wr_rdy", wr_rdy, 1);
    check("rst_wr_done", wr_done, 0);
    check("rst_rready", rready, 1);
    check("rst_bready", bready, 1);
    check("rst_arsize", arsize, 2);
    check("rst_arburst", arburst, 1);

    // 1: both clients single read, RR from ptr 0
    rd_req = 2'b11; rd_type = 2'b00;
    rd_addr = {32'h0000_2000, 32'h0000_1000};
    arready = 1'b1;
    settle();
    check("t1_grant0", rd_rdy, 2'b01);
    step();
    rd_req = 2'b10;
    settle();
    check("t1_arvalid0", arvalid, 1);
    check("t1_arid0", arid, 0);
    check("t1_araddr0", araddr, 32'h0000_1000);
    check("t1_arlen0", arlen, 0);
    check("t1_grant1", rd_rdy, 2'b10);
    step();
    rd_req = 2'b00;
    settle();
    check("t1_arid1", arid, 1);
    check("t1_araddr1", araddr, 32'h0000_2000);
    check("t1_no_grant", rd_rdy, 2'b00);
    step();
    settle();
    check("t1_ar_idle", arvalid, 0);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hDEAD0001; rlast = 1'b1;
    settle();
    check("t1_ret_id1", ret_valid, 2'b10);
    check("t1_ret_data1", ret_data, 32'hDEAD0001);
    check("t1_ret_last1", ret_last, 1);
    step();
    rid = 4'd0; rdata = 32'hDEAD0000;
    settle();
    check("t1_ret_id0", ret_valid, 2'b01);
    step();
    rvalid = 1'b0; rlast = 1'b0;

    // 2: client 1 line read
    rd_req = 2'b10; rd_type = 2'b10; rd_addr[63:32] = 32'h1c00_0040;
    settle();
    check("t2_grant", rd_rdy, 2'b10);
    step();
    rd_req = 2'b00;
    settle();
    check("t2_arid", arid, 1);
    check("t2_arlen", arlen, 3);
    check("t2_araddr", araddr, 32'h1c00_0040);
    step();
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rid = 4'd1; rdata = 32'hB000_0000 + 32'(k); rlast = (k == 3);
      settle();
      check("t2_ret_valid", ret_valid, 2'b10);
      check("t2_ret_data", ret_data, 32'hB000_0000 + 32'(k));
      check("t2_ret_last", ret_last, (k == 3));
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;

    // 3: line write, wready toggling
    start_line_write(32'h1c00_0100);
    settle();
    check("t3_wr_rdy", wr_rdy, 1);
    step();
    wr_req = 1'b0;
    settle();
    check("t3_awvalid", awvalid, 1);
    check("t3_awaddr", awaddr, 32'h1c00_0100);
    check("t3_awlen", awlen, 3);
    check("t3_awid", awid, WR_ID);
    check("t3_wr_rdy_busy", wr_rdy, 0);
    awready = 1'b1;
    step();
    awready = 1'b0;
    beat = 0; cyc = 0;
    while (beat < 4 && cyc < 20) begin
      wready = (cyc % 2 == 0);
      settle();
      check("t3_wvalid", wvalid, 1);
      if (wready) begin
        check("t3_wdata", wdata, exp_w[beat]);
        check("t3_wlast", wlast, (beat == 3));
        check("t3_wstrb", wstrb, 4'hf);
        beat++;
      end
      step();
      cyc++;
    end
    wready = 1'b0;
    check("t3_beats", beat, 4);
    settle();
    check("t3_wvalid_off", wvalid, 0);
    check("t3_no_done", wr_done, 0);
    bvalid = 1'b1;
    settle();
    check("t3_done", wr_done, 1);
    check("t3_rdy_in_rsp", wr_rdy, 0);
    step();
    bvalid = 1'b0;
    settle();
    check("t3_done_pulse", wr_done, 0);
    check("t3_rdy_after", wr_rdy, 1);

    // 4: read-after-write line hazard
    start_line_write(32'h1c00_0100);
    rd_req = 2'b01; rd_type = 2'b00; rd_addr[31:0] = 32'h1c00_010c;
    settle();
    check("t4_haz_accept", rd_rdy, 2'b00);
    step();
    wr_req = 1'b0;
    settle();
    check("t4_haz_aw", rd_rdy, 2'b00);
    rd_req = 2'b11; rd_addr[63:32] = 32'h1c00_0200;
    settle();
    check("t4_other_line", rd_rdy, 2'b10);
    step();
    rd_req = 2'b01;
    awready = 1'b1;
    settle();
    check("t4_haz_aw2", rd_rdy, 2'b00);
    step();
    awready = 1'b0; wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("t4_haz_dat", rd_rdy, 2'b00);
      step();
    end
    wready = 1'b0;
    settle();
    check("t4_haz_rsp", rd_rdy, 2'b00);
    bvalid = 1'b1;
    settle();
    check("t4_done", wr_done, 1);
    check("t4_haz_done", rd_rdy, 2'b00);
    step();
    bvalid = 1'b0;
    settle();
    check("t4_released", rd_rdy, 2'b01);
    step();
    rd_req = 2'b00;
    settle();
    check("t4_araddr", araddr, 32'h1c00_010c);
    rvalid = 1'b1; rlast = 1'b1; rid = 4'd0;
    step();
    rid = 4'd1;
    step();
    rvalid = 1'b0; rlast = 1'b0;

    // 5: single write with byte strobes
    wr_req = 1'b1; wr_type = 1'b0; wr_addr = 32'h1c00_0300; wr_wstrb = 4'b0110;
    wr_data = '0; wr_data[31:0] = 32'h1234_5678;
    step();
    wr_req = 1'b0;
    settle();
    check("t5_awlen", awlen, 0);
    check("t5_awvalid", awvalid, 1);
    awready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b1;
    settle();
    check("t5_wstrb", wstrb, 4'h6);
    check("t5_wlast", wlast, 1);
    check("t5_wdata", wdata, 32'h1234_5678);
    step();
    wready = 1'b0; bvalid = 1'b1;
    settle();
    check("t5_done", wr_done, 1);
    step();
    bvalid = 1'b0;

    // 6: reset during W_DAT beat 2 with a read pending
    rd_req = 2'b01; rd_type = 2'b01; rd_addr[31:0] = 32'h0000_3000;
    arready = 1'b0;
    settle();
    check("t6_grant", rd_rdy, 2'b01);
    step();
    rd_req = 2'b00;
    step();
    settle();
    check("t6_ar_stall", arvalid, 1);
    check("t6_ar_stable", araddr, 32'h0000_3000);
    arready = 1'b1;
    step();
    start_line_write(32'h1c00_0500);
    step();
    wr_req = 1'b0; awready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b1;
    step(); step();
    settle();
    check("t6_beat2", wdata, exp_w[2]);
    reset = 1'b1;
    step();
    reset = 1'b0; wready = 1'b0;
    settle();
    check("t6_arvalid", arvalid, 0);
    check("t6_awvalid", awvalid, 0);
    check("t6_wvalid", wvalid, 0);
    check("t6_wr_rdy", wr_rdy, 1);
    check("t6_ret_valid", ret_valid, 2'b00);
    rd_req = 2'b11; rd_type = 2'b00;
    rd_addr = {32'h0000_5000, 32'h0000_4000};
    settle();
    check("t6_ptr0", rd_rdy, 2'b01);
    step();
    rd_req = 2'b10;
    settle();
    check("t6_next", rd_rdy, 2'b10);
    step();
    rd_req = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
